alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
Shares the single combinational ALU (XLEN-wide operands, 4-bit funct_alu, combinational aluout) between two requesters: requester 0 is the execute stage and requester 1 is the address/branch-compare unit. The block accepts a request with a valid/ready handshake and registers the operands and function into the ALU. It then captures aluout and returns the result to the granted requester with a valid/ready handshake. Round-robin arbitration ensures neither requester starves. It sits between the core's issue logic and the alu instance.

Parameters:
XLEN, 32, operand/result width (must match the ALU instance)

Ports:
clk  in  1  core clock; all state updates on the rising edge
rst  in  1  reset, synchronous and active-high
req0_valid  in  1  requester 0 has an operation pending
req0_in1  in  XLEN  requester 0 operand 1
req0_in2  in  XLEN  requester 0 operand 2
req0_funct  in  4  requester 0 ALU function code
req0_ready  out  1  requester 0 request accepted this cycle
resp0_valid  out  1  result for requester 0 available
resp0_result  out  XLEN  result for requester 0
resp0_ready  in  1  requester 0 consumes result
req1_valid, req1_in1, req1_in2, req1_funct, req1_ready, resp1_valid, resp1_result, resp1_ready: same as requester 0, for requester 1
alu_in1  out  XLEN  registered operand 1 driven to the ALU
alu_in2  out  XLEN  registered operand 2 driven to the ALU
alu_funct  out  4  registered function code driven to the ALU
alu_out  in  XLEN  ALU combinational result
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset values: state=IDLE, alu_in1/alu_in2=0, alu_funct=4'b0000, result register=0, gnt_id=0, last_grant=1 (so requester 0 wins the first tie). All req*_ready, resp*_valid and busy are 0.
- FSM states: IDLE, EXEC, RESP.
- IDLE, arbitration:
  - If only one req*_valid is high, that requester is selected.
  - If both are high, select the requester that is not last_grant.
  - The selected req*_ready is asserted combinationally in this cycle; at most one ready is high at once. The ready signals are 0 in every other state.
  - On the edge: latch the selected operands and funct into the alu_in* and alu_funct registers, set gnt_id to the selected requester, set last_grant to gnt_id, and go to EXEC.
  - If no request is valid, stay in IDLE and keep the alu_in* registers unchanged.
- EXEC: lasts one cycle. The ALU settles on the registered inputs. On the edge, capture alu_out into the result register and go to RESP.
- RESP:
  - resp<gnt_id>_valid=1 and resp<gnt_id>_result=result register. The other requester's resp_valid=0.
  - Hold the result stable until resp<gnt_id>_ready is high, then go to IDLE on that edge.
  - New requests are not accepted in RESP.
- Latency and throughput:
  - Request accepted in cycle T, resp_valid first high in cycle T+2.
  - Minimum issue interval is 3 cycles, reached when resp_ready is held high.
- Handshake rules:
  - Requesters keep req*_valid and the operands stable until ready.
  - Deasserting valid before ready is allowed; the request is simply not taken.
  - resp*_result is don't-care while resp*_valid=0; it is implemented as the result register.
- Function codes are passed through unchecked. For undefined codes (e.g. 4'b0011), whatever the ALU drives, including X, is returned unchanged.
- Reset asserted mid-operation (EXEC or RESP): the transaction is dropped, no response is issued, and all state returns to reset values on that edge.
- Simultaneous events: a requester may raise a new req*_valid in the same cycle its resp_ready completes. That request is evaluated in the following IDLE cycle.

Test Plan:
- Single add: req0 with in1=0x17, in2=0x0A, funct=0000 → req0_ready at T, alu_funct=0000 at T+1, resp0_valid at T+2 with result 0x00000021, busy high from T+1 to T+2.
- Sub and shift via req1: in1=0x17, in2=0x0A, funct=1000 → resp1_result 0x0000000D. Then in1=0x80000015, in2=3, funct=1101 (SRA) → 0xF0000002, and with funct=0101 (SRL) → 0x10000002.
- Both valid after reset → req0 granted first, req1 second, req0 third (alternation). Responses are routed to the correct port, and resp0_valid and resp1_valid are never high together.
- Response backpressure: hold resp0_ready=0 for 5 cycles → resp0_valid and result stay stable; req1 (held valid) does not get ready until the cycle after resp0_ready=1.
- Reset in EXEC: apply rst for one cycle → no resp*_valid ever fires for that request, and all outputs return to reset values. A fresh req0 of 0x17 AND 0x0A (funct=0111) afterwards returns 0x00000002.
- Undefined funct 0011 on req0 → response handshake completes normally with the ALU's value passed through, and the FSM returns to IDLE.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between the execute stage
// (requester 0) and the address/branch-compare unit (requester 1).
//
// Handshake semantics (both request and response channels):
//   A transfer happens on a rising edge where valid and ready are both high.
//   The producer holds valid and its payload stable until that edge. It may
//   drop valid before ready is seen, and then nothing is transferred.
//   req*_ready is high only in IDLE, and only for the requester that wins
//   arbitration. resp*_valid is high only in RESP, and only for the granted
//   requester.
//
// Flow: IDLE (arbitrate, latch operands) -> EXEC (ALU settles) ->
//       RESP (hold result until consumed) -> IDLE.
module alu_arbiter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  // requester 0: execute stage
  input  logic            req0_valid,
  input  logic [XLEN-1:0] req0_in1,
  input  logic [XLEN-1:0] req0_in2,
  input  logic [3:0]      req0_funct,
  output logic            req0_ready,
  output logic            resp0_valid,
  output logic [XLEN-1:0] resp0_result,
  input  logic            resp0_ready,
  // requester 1: address/branch-compare unit
  input  logic            req1_valid,
  input  logic [XLEN-1:0] req1_in1,
  input  logic [XLEN-1:0] req1_in2,
  input  logic [3:0]      req1_funct,
  output logic            req1_ready,
  output logic            resp1_valid,
  output logic [XLEN-1:0] resp1_result,
  input  logic            resp1_ready,
  // shared ALU
  output logic [XLEN-1:0] alu_in1,
  output logic [XLEN-1:0] alu_in2,
  output logic [3:0]      alu_funct,
  input  logic [XLEN-1:0] alu_out,
  // status
  output logic            busy,
  output logic [1:0]      state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic            gnt_id_q;
  logic            last_grant_q;
  logic [XLEN-1:0] result_q;

  logic            any_req;
  logic            sel_id;
  logic            accept;
  logic            capture;
  logic            resp_taken;

  // Round-robin pick: on a tie, give the grant to whoever did not win last.
  always_comb begin
    any_req = req0_valid | req1_valid;
    sel_id  = 1'b0;
    if (req0_valid && req1_valid) begin
      sel_id = ~last_grant_q;
    end else if (req1_valid) begin
      sel_id = 1'b1;
    end
  end

  // The granted requester's consume signal ends the RESP phase.
  always_comb begin
    resp_taken = gnt_id_q ? resp1_ready : resp0_ready;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic, plus the per-state strobes and the request readies.
  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    capture    = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          accept     = 1'b1;
          req0_ready = ~sel_id;
          req1_ready = sel_id;
          state_d    = EXEC;
        end
      end
      EXEC: begin
        capture = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        if (resp_taken) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Operand/function registers that feed the ALU. They are loaded only on
  // acceptance and hold their value otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_in1   <= '0;
      alu_in2   <= '0;
      alu_funct <= 4'b0000;
    end else if (accept) begin
      alu_in1   <= sel_id ? req1_in1   : req0_in1;
      alu_in2   <= sel_id ? req1_in2   : req0_in2;
      alu_funct <= sel_id ? req1_funct : req0_funct;
    end
  end

  // Grant bookkeeping. last_grant takes the requester being granted now, so
  // that the next tie goes to the other requester.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_id_q     <= 1'b0;
      last_grant_q <= 1'b1;
    end else if (accept) begin
      gnt_id_q     <= sel_id;
      last_grant_q <= sel_id;
    end
  end

  // Capture the settled ALU output at the end of EXEC. Function codes are
  // not checked, so whatever the ALU drives is returned unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
    end else if (capture) begin
      result_q <= alu_out;
    end
  end

  // Route the response to the granted requester. Both result buses show the
  // register; each one is only meaningful while its valid is high.
  always_comb begin
    resp0_valid  = (state_q == RESP) && !gnt_id_q;
    resp1_valid  = (state_q == RESP) &&  gnt_id_q;
    resp0_result = result_q;
    resp1_result = result_q;
    busy         = (state_q != IDLE);
    state_dbg    = state_q;
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: directed vectors with hand-computed results.
// The driver pushes expected results into per-requester queues, and a
// monitor pops and compares them on each response handshake.
module tb_alu_arbiter;

  localparam int XLEN = 32;

  logic            clk;
  logic            rst;
  logic            req0_valid;
  logic [XLEN-1:0] req0_in1;
  logic [XLEN-1:0] req0_in2;
  logic [3:0]      req0_funct;
  logic            req0_ready;
  logic            resp0_valid;
  logic [XLEN-1:0] resp0_result;
  logic            resp0_ready;
  logic            req1_valid;
  logic [XLEN-1:0] req1_in1;
  logic [XLEN-1:0] req1_in2;
  logic [3:0]      req1_funct;
  logic            req1_ready;
  logic            resp1_valid;
  logic [XLEN-1:0] resp1_result;
  logic            resp1_ready;
  logic [XLEN-1:0] alu_in1;
  logic [XLEN-1:0] alu_in2;
  logic [3:0]      alu_funct;
  logic [XLEN-1:0] alu_out;
  logic            busy;
  logic [1:0]      state_dbg;

  int checks = 0;
  int errors = 0;

  logic [XLEN-1:0] exp0_q[$];
  logic [XLEN-1:0] exp1_q[$];
  logic            gnt_log[$];

  alu_arbiter #(.XLEN(XLEN)) dut (
    .clk          (clk),
    .rst          (rst),
    .req0_valid   (req0_valid),
    .req0_in1     (req0_in1),
    .req0_in2     (req0_in2),
    .req0_funct   (req0_funct),
    .req0_ready   (req0_ready),
    .resp0_valid  (resp0_valid),
    .resp0_result (resp0_result),
    .resp0_ready  (resp0_ready),
    .req1_valid   (req1_valid),
    .req1_in1     (req1_in1),
    .req1_in2     (req1_in2),
    .req1_funct   (req1_funct),
    .req1_ready   (req1_ready),
    .resp1_valid  (resp1_valid),
    .resp1_result (resp1_result),
    .resp1_ready  (resp1_ready),
    .alu_in1      (alu_in1),
    .alu_in2      (alu_in2),
    .alu_funct    (alu_funct),
    .alu_out      (alu_out),
    .busy         (busy),
    .state_dbg    (state_dbg)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- ALU model (RV32 funct_alu encoding) ----------------
  always_comb begin
    alu_out = '0;
    case (alu_funct)
      4'b0000: alu_out = alu_in1 + alu_in2;
      4'b1000: alu_out = alu_in1 - alu_in2;
      4'b0001: alu_out = alu_in1 << alu_in2[4:0];
      4'b0100: alu_out = alu_in1 ^ alu_in2;
      4'b0101: alu_out = alu_in1 >> alu_in2[4:0];
      4'b1101: alu_out = $unsigned($signed(alu_in1) >>> alu_in2[4:0]);
      4'b0110: alu_out = alu_in1 | alu_in2;
      4'b0111: alu_out = alu_in1 & alu_in2;
      default: alu_out = 32'hBAD0_0000 ^ alu_in1;  // undefined code marker
    endcase
  end

  // ---------------- check helpers ----------------
  function automatic void chk(string name, logic [XLEN-1:0] act, logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void fail(string name);
    checks++;
    errors++;
    $display("FAIL %s (t=%0t)", name, $time);
  endfunction

  // ---------------- monitor / scoreboard ----------------
  // Pop and compare on each response handshake, check that the two response
  // valids are never high together, and log the order of request grants.
  always @(negedge clk) begin
    if (!rst) begin
      chk("resp_valid_exclusive", {31'd0, resp0_valid & resp1_valid}, 32'd0);
      if (req0_ready) gnt_log.push_back(1'b0);
      if (req1_ready) gnt_log.push_back(1'b1);
      if (resp0_valid && resp0_ready) begin
        if (exp0_q.size() == 0) fail("resp0_unexpected");
        else chk("resp0_result", resp0_result, exp0_q.pop_front());
      end
      if (resp1_valid && resp1_ready) begin
        if (exp1_q.size() == 0) fail("resp1_unexpected");
        else chk("resp1_result", resp1_result, exp1_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Present a request, wait (bounded) for ready, push the expected result,
  // then drop valid after the accepting edge.
  task automatic issue(input int id, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic [3:0] f, input logic [XLEN-1:0] exp);
    bit got = 0;
    int n = 0;
    if (id == 0) begin
      req0_in1 = a; req0_in2 = b; req0_funct = f; req0_valid = 1'b1;
    end else begin
      req1_in1 = a; req1_in2 = b; req1_funct = f; req1_valid = 1'b1;
    end
    while (!got && n < 50) begin
      @(negedge clk);
      if ((id == 0) ? req0_ready : req1_ready) begin
        got = 1;
        if (id == 0) exp0_q.push_back(exp);
        else exp1_q.push_back(exp);
      end
      @(posedge clk);
      #1;
      n++;
    end
    if (!got) fail((id == 0) ? "req0_ready_timeout" : "req1_ready_timeout");
    if (id == 0) req0_valid = 1'b0;
    else req1_valid = 1'b0;
  endtask

  // Wait (bounded) until every expected response has been consumed.
  task automatic drain();
    int n = 0;
    while ((exp0_q.size() != 0 || exp1_q.size() != 0) && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (exp0_q.size() != 0 || exp1_q.size() != 0) fail("drain_timeout");
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1;
    req0_valid = 1'b0; req0_in1 = '0; req0_in2 = '0; req0_funct = '0;
    req1_valid = 1'b0; req1_in1 = '0; req1_in2 = '0; req1_funct = '0;
    resp0_ready = 1'b1;
    resp1_ready = 1'b1;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_alu_in1", alu_in1, 32'd0);
    chk("rst_alu_in2", alu_in2, 32'd0);
    chk("rst_alu_funct", {28'd0, alu_funct}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_resp_valid", {30'd0, resp1_valid, resp0_valid}, 32'd0);
    chk("rst_req_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Single add with cycle-exact latency
    req0_in1 = 32'h17; req0_in2 = 32'h0A; req0_funct = 4'b0000; req0_valid = 1'b1;
    @(negedge clk);
    chk("add_req0_ready_T", {31'd0, req0_ready}, 32'd1);
    chk("add_req1_ready_T", {31'd0, req1_ready}, 32'd0);
    chk("add_busy_T", {31'd0, busy}, 32'd0);
    exp0_q.push_back(32'h0000_0021);
    @(posedge clk);
    #1 req0_valid = 1'b0;
    @(negedge clk);
    chk("add_busy_T1", {31'd0, busy}, 32'd1);
    chk("add_alu_funct_T1", {28'd0, alu_funct}, 32'd0);
    chk("add_alu_in1_T1", alu_in1, 32'h17);
    chk("add_alu_in2_T1", alu_in2, 32'h0A);
    chk("add_resp0_valid_T1", {31'd0, resp0_valid}, 32'd0);
    @(negedge clk);
    chk("add_resp0_valid_T2", {31'd0, resp0_valid}, 32'd1);
    chk("add_busy_T2", {31'd0, busy}, 32'd1);
    chk("add_resp1_valid_T2", {31'd0, resp1_valid}, 32'd0);
    @(negedge clk);
    chk("add_busy_T3", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;

    // Sub and shifts via requester 1
    issue(1, 32'h17, 32'h0A, 4'b1000, 32'h0000_000D);
    issue(1, 32'h8000_0015, 32'd3, 4'b1101, 32'hF000_0002);
    issue(1, 32'h8000_0015, 32'd3, 4'b0101, 32'h1000_0002);
    drain();

    // Alternation with both requesters valid
    gnt_log.delete();
    fork
      issue(0, 32'd5, 32'd3, 4'b0000, 32'd8);
      issue(1, 32'd9, 32'd4, 4'b1000, 32'd5);
    join
    fork
      issue(0, 32'hF0, 32'h0F, 4'b0100, 32'hFF);
      issue(1, 32'd1, 32'd4, 4'b0001, 32'h10);
    join
    drain();
    if (gnt_log.size() != 4) begin
      chk("alt_grant_count", gnt_log.size(), 32'd4);
    end else begin
      chk("alt_grant_0", {31'd0, gnt_log[0]}, 32'd0);
      chk("alt_grant_1", {31'd0, gnt_log[1]}, 32'd1);
      chk("alt_grant_2", {31'd0, gnt_log[2]}, 32'd0);
      chk("alt_grant_3", {31'd0, gnt_log[3]}, 32'd1);
    end

    // Response backpressure on requester 0 while requester 1 waits
    resp0_ready = 1'b0;
    issue(0, 32'h100, 32'h23, 4'b0000, 32'h123);
    req1_in1 = 32'd2; req1_in2 = 32'd3; req1_funct = 4'b0000; req1_valid = 1'b1;
    @(negedge clk);
    chk("bp_req1_ready_exec", {31'd0, req1_ready}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("bp_resp0_valid_hold", {31'd0, resp0_valid}, 32'd1);
      chk("bp_resp0_result_hold", resp0_result, 32'h123);
      chk("bp_req1_ready_hold", {31'd0, req1_ready}, 32'd0);
    end
    @(posedge clk);
    #1 resp0_ready = 1'b1;
    @(negedge clk);
    chk("bp_req1_ready_release", {31'd0, req1_ready}, 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("bp_req1_ready_after", {31'd0, req1_ready}, 32'd1);
    if (req1_ready) exp1_q.push_back(32'd5);
    @(posedge clk);
    #1 req1_valid = 1'b0;
    drain();

    // Reset during EXEC drops the transaction
    @(posedge clk);
    #1;
    req0_in1 = 32'h55; req0_in2 = 32'h1; req0_funct = 4'b0000; req0_valid = 1'b1;
    @(negedge clk);
    chk("rx_req0_ready", {31'd0, req0_ready}, 32'd1);
    @(posedge clk);
    #1 begin
      req0_valid = 1'b0;
      rst = 1'b1;
    end
    @(negedge clk);
    chk("rx_busy_exec", {31'd0, busy}, 32'd1);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rx_busy", {31'd0, busy}, 32'd0);
    chk("rx_state", {30'd0, state_dbg}, 32'd0);
    chk("rx_alu_in1", alu_in1, 32'd0);
    chk("rx_alu_in2", alu_in2, 32'd0);
    chk("rx_alu_funct", {28'd0, alu_funct}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("rx_no_resp", {30'd0, resp1_valid, resp0_valid}, 32'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    issue(0, 32'h17, 32'h0A, 4'b0111, 32'h0000_0002);
    drain();

    // Undefined function code passes the ALU's value through
    issue(0, 32'h1234, 32'h5678, 4'b0011, 32'hBAD0_1234);
    drain();
    repeat (2) @(negedge clk);
    chk("undef_busy_idle", {31'd0, busy}, 32'd0);
    chk("undef_state_idle", {30'd0, state_dbg}, 32'd0);

    // Final report
    chk("final_exp0_empty", exp0_q.size(), 32'd0);
    chk("final_exp1_empty", exp1_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    fail("global_timeout");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
